// File: rtl/melody_pkg.sv
// Shared types and constants for the melody sequencer: FSM states, note half-periods at 100 MHz,
// and the default 16-slot melody table.
package melody_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_PLAY, ST_PAUSE} state_t;

  localparam int          NOTE_COUNT = 16;
  localparam logic [15:0] AMP_STEP   = 16'h0800;

  typedef logic [17:0] div_t;

  // Half-period in clk cycles for each pitch; REST silences the slot
  localparam div_t REST = 18'd0;
  localparam div_t C4   = 18'd191113;
  localparam div_t D4   = 18'd170265;
  localparam div_t E4   = 18'd151685;
  localparam div_t F4   = 18'd143172;
  localparam div_t G4   = 18'd127551;
  localparam div_t A4   = 18'd113636;
  localparam div_t B4   = 18'd101239;
  localparam div_t C5   = 18'd95557;

  // Listed slot 15 first so that slot 0 lands in the lowest index
  localparam div_t [NOTE_COUNT-1:0] MELODY_DEFAULT = {
    C5, C4, REST, D4, E4, F4, G4, B4,
    A4, A4, REST, G4, F4, E4, D4, C4
  };

  function automatic logic [15:0] amp_of(input logic [2:0] vol);
    return 16'(vol) * AMP_STEP;
  endfunction

endpackage

// File: rtl/melody_rom.sv
// Melody lookup: 4-bit slot index to 18-bit half-period divisor (0 = rest).
// Latency: combinational. Backpressure: none.
module melody_rom
  import melody_pkg::*;
#(
  parameter div_t [NOTE_COUNT-1:0] TABLE = MELODY_DEFAULT
) (
  input  logic [3:0] idx,
  output div_t       div
);

  assign div = TABLE[idx];

endmodule

// File: rtl/melody_sequencer.sv
// Square-wave melody player: 16 slots of BEAT_CYCLES each, samples latched on sample_req; MELODY_LOOP_EN loops playback.
// Latency: samples/sample_vld one cycle after sample_req; busy one cycle after start. Backpressure: none, serializer paces via sample_req.
module melody_sequencer
  import melody_pkg::*;
#(
  parameter int                     BEAT_CYCLES = 25_000_000,
  parameter div_t [NOTE_COUNT-1:0]  ROM_TABLE   = MELODY_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        stop,
  input  logic        pause,
  input  logic [2:0]  vol,
  input  logic        sample_req,
  output logic [15:0] sample_l,
  output logic [15:0] sample_r,
  output logic        sample_vld,
  output logic [3:0]  note_idx,
  output logic        busy,
  output logic        done
);

  localparam int             BW        = 25;
  localparam logic [BW-1:0]  BEAT_LAST = BW'(BEAT_CYCLES - 1);
  localparam logic [3:0]     LAST_NOTE = 4'(NOTE_COUNT - 1);

  state_t        state, state_nxt;
  logic [BW-1:0] beat_cnt, beat_nxt;
  div_t          tone_cnt, tone_nxt;
  logic          phase, phase_nxt;
  logic [3:0]    note_nxt;
  logic          done_nxt;
  div_t          div;
  logic [15:0]   amp;
  logic [15:0]   tone;

  melody_rom #(.TABLE(ROM_TABLE)) u_rom (
    .idx (note_idx),
    .div (div)
  );

  always_comb begin
    state_nxt = state;
    beat_nxt  = beat_cnt;
    tone_nxt  = tone_cnt;
    phase_nxt = phase;
    note_nxt  = note_idx;
    done_nxt  = 1'b0;
    if (stop) begin
      state_nxt = ST_IDLE;
      beat_nxt  = '0;
      tone_nxt  = '0;
      phase_nxt = 1'b0;
      note_nxt  = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state_nxt = ST_PLAY;
            beat_nxt  = '0;
            tone_nxt  = '0;
            phase_nxt = 1'b0;
            note_nxt  = '0;
          end
        end
        ST_PLAY: begin
          if (pause) begin
            state_nxt = ST_PAUSE;
          end else if (beat_cnt == BEAT_LAST) begin
            // Slot boundary: every note starts from a clean tone phase
            beat_nxt  = '0;
            tone_nxt  = '0;
            phase_nxt = 1'b0;
            if (note_idx == LAST_NOTE) begin
              done_nxt = 1'b1;
              note_nxt = '0;
`ifndef MELODY_LOOP_EN
              state_nxt = ST_IDLE;
`endif
            end else begin
              note_nxt = note_idx + 4'd1;
            end
          end else begin
            beat_nxt = beat_cnt + BW'(1);
            if (div == '0) begin
              tone_nxt = '0;
            end else if (tone_cnt == div - 18'd1) begin
              tone_nxt  = '0;
              phase_nxt = ~phase;
            end else begin
              tone_nxt = tone_cnt + 18'd1;
            end
          end
        end
        ST_PAUSE: begin
          if (!pause) state_nxt = ST_PLAY;
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  assign amp  = amp_of(vol);
  assign tone = (state == ST_PLAY && div != '0) ? (phase ? amp : -amp) : 16'h0000;
  assign busy = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      beat_cnt   <= '0;
      tone_cnt   <= '0;
      phase      <= 1'b0;
      note_idx   <= '0;
      done       <= 1'b0;
      sample_l   <= '0;
      sample_r   <= '0;
      sample_vld <= 1'b0;
    end else begin
      state      <= state_nxt;
      beat_cnt   <= beat_nxt;
      tone_cnt   <= tone_nxt;
      phase      <= phase_nxt;
      note_idx   <= note_nxt;
      done       <= done_nxt;
      sample_vld <= sample_req;
      // Latches the tone seen before this edge, even across a state change
      if (sample_req) begin
        sample_l <= tone;
        sample_r <= tone;
      end
    end
  end

endmodule
